pwm_duty_ramp_ctrl: RTL
=======================

# pwm_duty_ramp_ctrl

Controller for the PWM datapath's duty-cycle input. It owns the `pwm_duty_cycle` value fed to `pwm_peripheral` and arbitrates between two sources. The first is immediate host writes decoded by the SPI peripheral. The second is autonomous ramps that step the duty cycle toward a target at a programmable rate. It sits between `spi_peripheral` and `pwm_peripheral` in the top level.

## Interface
- `RESET_DUTY`, 8'h00: value of `duty` after reset.
- `PERIOD_W`, 16: width of the step-period counter and `period` port.
- `clk` input 1: system clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `host_wr` input 1: single-cycle host write strobe from SPI decode.
- `host_duty` input 8: host write data, sampled when `host_wr`=1.
- `start` input 1: ramp request, sampled every edge.
- `target` input 8: ramp end value, latched on accepted `start`.
- `step` input 8: magnitude per update, latched on accepted `start`; 0 treated as 1.
- `period` input PERIOD_W: clocks between updates, latched on accepted `start`; 0 treated as 1.
- `abort` input 1: stop an active ramp.
- `duty` output 8: registered duty cycle to `pwm_peripheral`.
- `busy` output 1: high while in RAMP.
- `done` output 1: one-cycle pulse on ramp completion.

## Operation
- States: IDLE, RAMP. Reset state IDLE.
- Reset values: `duty`=RESET_DUTY, `busy`=0, `done`=0, period counter 0, latched target/step/period 0.
- Priority per edge, highest first: `rst` > `host_wr` > `abort` > ramp update > `start`.
- `host_wr`=1, any state:
  - `duty`<=`host_duty` at the next edge.
  - State goes to IDLE, with no `done`.
  - `start` and `abort` on the same cycle are ignored.
- `start` in IDLE, no `host_wr`:
  - Accepted. Latch `target`, effective step and effective period; counter<=period_eff-1.
  - If `target`==`duty`: stay IDLE, `done`=1 for the next cycle, `busy` stays 0.
  - Otherwise go to RAMP.
- `start` while in RAMP: ignored, with no effect on the latched parameters.
- In RAMP, when counter≠0: counter decrements.
- In RAMP, when counter==0:
  - Counter reloads period_eff-1.
  - `duty` moves toward target by step_eff. Direction is up if target>duty, else down.
  - Compute in 9 bits and clamp to target; never overshoot, never wrap past 0/255.
- When the update makes `duty`==target: at the same edge, state goes to IDLE and `done`=1 for one cycle.
- `abort` in RAMP, no `host_wr`: go to IDLE next edge, `duty` holds its current value, no `done`, counter not reloaded.
- `abort` in IDLE: no effect, and any simultaneous `start` is ignored.
- `rst` asserted mid-ramp: all outputs take their reset values immediately (asynchronous). After release, state is IDLE.

## Timing
- `duty`, `busy` and `done` are all registered. There is no combinational path from inputs to outputs.
- Accept edge E0 (`start` sampled high): `busy`=1 after E0.
- The first `duty` update is at edge E0+period_eff.
- Subsequent updates follow every period_eff edges.
- Ramp of distance D completes at edge E0+period_eff×ceil(D/step_eff).
- At that edge the final `duty`, `done`=1 and `busy`=0 all appear together.
- `done` is high for exactly one cycle.
- A new `start` is accepted on the cycle `done` is high, since the state is already IDLE.
- Host write latency is one edge in both states.

## Test plan
- Async reset mid-ramp: `rst` pulsed between edges during a ramp gives `duty`=0x00, `busy`=0, `done`=0 before the next edge. The next `start` is accepted normally.
- Up ramp: `duty`=0, `start` with target=100, step=30, period=4.
  - `duty` is 30, 60, 90, 100 at E0+4, +8, +12, +16.
  - `done`=1 only in the cycle after E0+16, together with `busy` falling.
- Down ramp with zero step and period: `host_wr` 100, then `start` with target=97, step=0, period=0.
  - `duty` is 99, 98, 97 on edges E0+1..E0+3.
  - `done` coincides with 97.
- No-op ramp: `duty`=0x40, `start` with target=0x40 gives `done`=1 for one cycle after E0, `busy` never high, `duty` unchanged.
- Host override: ramp 0 to 200 with step=1, period=2. `host_wr` with 0x10 at duty≈50 gives `duty`=0x10 next edge, `busy`=0, no `done`. A `start` issued mid-ramp before the override has no effect.
- Abort priority: mid-ramp, `abort`=1 gives `duty` frozen and IDLE with no `done`. `abort`+`start` together in IDLE leave state IDLE. `host_wr`+`abort` together apply the host value.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl.sv
// Duty-cycle owner for the PWM datapath: applies immediate host writes and
// runs autonomous clamped ramps toward a target at a programmable step rate.
module pwm_duty_ramp_ctrl #(
    parameter logic [7:0] RESET_DUTY = 8'h00,
    parameter int         PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                host_wr,
    input  logic [7:0]          host_duty,
    input  logic                start,
    input  logic [7:0]          target,
    input  logic [7:0]          step,
    input  logic [PERIOD_W-1:0] period,
    input  logic                abort,
    output logic [7:0]          duty,
    output logic                busy,
    output logic                done
);

    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t              state_reg, state_next;
    logic [7:0]          duty_reg, duty_next;
    logic                done_reg, done_next;
    logic [PERIOD_W-1:0] cnt_reg, cnt_next;
    logic [7:0]          target_reg, target_next;
    logic [7:0]          step_reg, step_next;
    logic [PERIOD_W-1:0] period_reg, period_next;

    logic [7:0]          step_eff;
    logic [PERIOD_W-1:0] period_eff;
    logic [8:0]          up_sum;
    logic [8:0]          dn_diff;
    logic [7:0]          stepped;

    assign step_eff   = (step == 8'd0) ? 8'd1 : step;
    assign period_eff = (period == '0) ? ONE : period;

    // Next duty value one step toward the target; the 9-bit sum/difference
    // exposes overflow and underflow so the result clamps instead of wrapping.
    always_comb begin
        up_sum  = {1'b0, duty_reg} + {1'b0, step_reg};
        dn_diff = {1'b0, duty_reg} - {1'b0, step_reg};
        stepped = target_reg;
        if (target_reg > duty_reg) begin
            if (up_sum < {1'b0, target_reg})
                stepped = up_sum[7:0];
        end else begin
            if (!dn_diff[8] && (dn_diff[7:0] > target_reg))
                stepped = dn_diff[7:0];
        end
    end

    always_comb begin
        state_next  = state_reg;
        duty_next   = duty_reg;
        done_next   = 1'b0;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        step_next   = step_reg;
        period_next = period_reg;
        if (host_wr) begin
            duty_next  = host_duty;
            state_next = IDLE;
        end else if (state_reg == RAMP) begin
            if (abort) begin
                state_next = IDLE;
            end else if (cnt_reg == '0) begin
                cnt_next  = period_reg - ONE;
                duty_next = stepped;
                if (stepped == target_reg) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end else begin
                cnt_next = cnt_reg - ONE;
            end
        end else if (start && !abort) begin
            target_next = target;
            step_next   = step_eff;
            period_next = period_eff;
            cnt_next    = period_eff - ONE;
            if (target == duty_reg)
                done_next = 1'b1;
            else
                state_next = RAMP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            duty_reg   <= RESET_DUTY;
            done_reg   <= 1'b0;
            cnt_reg    <= '0;
            target_reg <= 8'd0;
            step_reg   <= 8'd0;
            period_reg <= '0;
        end else begin
            state_reg  <= state_next;
            duty_reg   <= duty_next;
            done_reg   <= done_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
            step_reg   <= step_next;
            period_reg <= period_next;
        end
    end

    assign duty = duty_reg;
    assign busy = (state_reg == RAMP);
    assign done = done_reg;

endmodule
